debug_frame_sched: RTL and testbench
====================================

DEBUG_FRAME_SCHED -- requirements
Module: debug_frame_sched

Interface
REQ-001 SHALL have parameter W, default 16: sample width in bits; a multiple of 8.
REQ-002 SHALL have parameter NCH, default 8: number of sample channels.
REQ-003 SHALL have parameter DIV, default 12: baud rate is clk/DIV; passed to uart_tx as DIV-2.
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port sample_strobe  in  1  request snapshot of samples.
REQ-007 SHALL have port samples  in  NCH*W  signed samples; channel k at bits [k*W +: W].
REQ-008 SHALL have port evt_valid  in  1  event request.
REQ-009 SHALL have port evt_code  in  8  event code.
REQ-010 SHALL have port evt_ready  out  1  event slot empty.
REQ-011 SHALL have port tx_o  out  1  UART serial line.
REQ-012 SHALL have port busy  out  1  frame in progress.
REQ-013 SHALL have port drop_cnt  out  8  dropped sample strobes since last event frame.

Function
REQ-014 SHALL, on sample_strobe with snapshot slot empty, capture all samples in that cycle and set sample-pending.
REQ-015 SHALL, on sample_strobe with sample-pending set, leave the snapshot unchanged and increment drop_cnt, saturating at 255.
REQ-016 SHALL, on evt_valid && evt_ready, capture evt_code and set event-pending; evt_ready = !event-pending.
REQ-017 SHALL use FSM states IDLE, HDR1, HDR2, TYPE, PAY, CSUM, one state per byte slot.
REQ-018 SHALL, in IDLE with any request pending, grant one source and enter HDR1 the next cycle.
REQ-019 SHALL grant round-robin when both are pending: pick the source not granted last; last_grant resets to event, so samples win first.
REQ-020 SHALL drive valid high with the state's byte in HDR1..CSUM; a byte is consumed in the cycle valid && ack, and only then does the FSM advance.
REQ-021 SHALL emit bytes 0xBE, then 0xEF, then type byte: 0x01 for a sample frame, 0x02 for an event frame.
REQ-022 SHALL emit sample payload as NCH*W/8 bytes: channel 0 first, each channel big-endian (MSB byte first).
REQ-023 SHALL emit event payload as 2 bytes: evt_code, then drop_cnt as sampled when that byte is presented.
REQ-024 SHALL clear sample-pending on ack of the last sample payload byte; a strobe in that same cycle SHALL capture new samples without counting a drop.
REQ-025 SHALL clear event-pending on ack of the last event payload byte.
REQ-026 SHALL clear drop_cnt on ack of the drop_cnt byte; a drop in that same cycle SHALL leave drop_cnt at 1.
REQ-027 SHALL deassert valid and return to IDLE after the final byte's ack; busy = (state != IDLE).
REQ-028 SHALL hold no grant change mid-frame; requests arriving during a frame wait for IDLE.

Reset
REQ-029 SHALL, on rst (including mid-frame), set state IDLE, valid 0, both pending flags 0, drop_cnt 0, last_grant=event, busy 0, evt_ready 1, with tx_o idle high via uart_tx reset; any partial frame is abandoned.

Configuration
REQ-030 SHALL, with DEBUG_FRAME_CSUM_EN defined, send a CSUM byte after the payload, equal to the XOR of the type byte and all payload bytes.
REQ-031 SHALL, without DEBUG_FRAME_CSUM_EN, skip the CSUM state: the last payload ack returns to IDLE.

Structure
REQ-032 SHALL place MAGIC1/MAGIC2, the type codes and the FSM state enum in package debug_frame_pkg.
REQ-033 SHALL instantiate the existing uart_tx as its one sub-module (data/valid/ack/div interface).

Verification
REQ-034 SHALL verify: reset, then one strobe with ch0=0x1234, ch7=0x8001 and others 0 -> bytes BE EF 01 12 34 ... 80 01 [CSUM] and busy low afterwards.
REQ-035 SHALL verify: evt_code=0x5A with no drops -> frame BE EF 02 5A 00, CSUM byte 0x58 when enabled; evt_ready low until 00 is acked.
REQ-036 SHALL verify: strobe and event in the same cycle from reset -> sample frame first, then event frame; a second simultaneous pair -> event first.
REQ-037 SHALL verify: 300 strobes during one frame -> drop_cnt=255, and the next event frame carries FF.
REQ-038 SHALL verify: rst asserted after byte 5 of a sample frame -> tx_o idle high, busy 0, drop_cnt 0, evt_ready 1; the next strobe yields a complete fresh frame.
REQ-039 SHALL verify: strobe coincident with the last sample payload ack -> no drop, and a second frame with the new values follows.

Source files
------------

// File: rtl/debug_frame_sched_pkg.sv
// Shared constants and state encoding for the debug frame scheduler.
package debug_frame_pkg;

  localparam logic [7:0] MAGIC1      = 8'hBE;
  localparam logic [7:0] MAGIC2      = 8'hEF;
  localparam logic [7:0] TYPE_SAMPLE = 8'h01;
  localparam logic [7:0] TYPE_EVENT  = 8'h02;

  // One state per byte slot of the outgoing frame.
  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    HDR2,
    TYPE,
    PAY,
    CSUM
  } frame_state_e;

  typedef enum logic {
    SRC_SAMPLE = 1'b0,
    SRC_EVENT  = 1'b1
  } src_e;

endpackage

// File: rtl/debug_frame_sched_uart_tx.sv
// 8N1 UART transmitter; accepts a byte when idle (ack) and holds each bit div_i+2 cycles.
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ack_o,
  input  logic [15:0] div_i,
  output logic        tx_o
);

  logic        busy_q;
  logic [8:0]  shreg_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] tmr_q;
  logic        tx_q;

  assign ack_o = valid_i && !busy_q;
  assign tx_o  = tx_q;

  // bit_cnt_q counts the bits still to present after the current one (start..stop).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      shreg_q   <= '1;
      bit_cnt_q <= 4'd0;
      tmr_q     <= 16'd0;
      tx_q      <= 1'b1;
    end else if (!busy_q) begin
      if (valid_i) begin
        busy_q    <= 1'b1;
        shreg_q   <= {1'b1, data_i};
        bit_cnt_q <= 4'd9;
        tmr_q     <= div_i + 16'd1;
        tx_q      <= 1'b0;
      end
    end else if (tmr_q == 16'd0) begin
      if (bit_cnt_q == 4'd0) begin
        busy_q <= 1'b0;
      end else begin
        tx_q      <= shreg_q[0];
        shreg_q   <= {1'b1, shreg_q[8:1]};
        bit_cnt_q <= bit_cnt_q - 4'd1;
        tmr_q     <= div_i + 16'd1;
      end
    end else begin
      tmr_q <= tmr_q - 16'd1;
    end
  end

endmodule

// File: rtl/debug_frame_sched.sv
// Debug frame scheduler: round-robin between sample snapshots and events, framed over UART.
// Optional trailing XOR checksum byte is enabled by defining DEBUG_FRAME_CSUM_EN.
module debug_frame_sched
  import debug_frame_pkg::*;
#(
  parameter int W   = 16,
  parameter int NCH = 8,
  parameter int DIV = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_strobe,
  input  logic [NCH*W-1:0] samples,
  input  logic             evt_valid,
  input  logic [7:0]       evt_code,
  output logic             evt_ready,
  output logic             tx_o,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int NB  = NCH * W / 8;
  localparam int BPC = W / 8;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;

  frame_state_e     state_q, state_d;
  src_e             src_q, src_d;
  src_e             last_grant_q, last_grant_d;
  logic             samp_pend_q;
  logic             evt_pend_q;
  logic [NCH*W-1:0] snap_q;
  logic [7:0]       evt_code_q;
  logic [7:0]       drop_cnt_q;
  logic [IW-1:0]    pay_idx_q;
`ifdef DEBUG_FRAME_CSUM_EN
  logic [7:0]       csum_q;
`endif

  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ack;
  logic       pay_last;
  logic [7:0] pay_byte;
  logic       samp_done;
  logic       evt_done;
  logic       samp_take;
  logic       samp_drop;
  logic [7:0] snap_bytes [NB];

  // Channel 0 first, each channel MSB byte first.
  for (genvar j = 0; j < NB; j++) begin : g_bytes
    assign snap_bytes[j] = snap_q[(j / BPC) * W + (BPC - 1 - (j % BPC)) * 8 +: 8];
  end

  assign pay_last = (src_q == SRC_SAMPLE) ? (pay_idx_q == IW'(NB - 1)) : (pay_idx_q == IW'(1));
  assign pay_byte = (src_q == SRC_SAMPLE) ? snap_bytes[pay_idx_q] :
                    ((pay_idx_q == IW'(0)) ? evt_code_q : drop_cnt_q);

  assign samp_done = (state_q == PAY) && (src_q == SRC_SAMPLE) && pay_last && tx_ack;
  assign evt_done  = (state_q == PAY) && (src_q == SRC_EVENT) && pay_last && tx_ack;
  assign samp_take = sample_strobe && (!samp_pend_q || samp_done);
  assign samp_drop = sample_strobe && samp_pend_q && !samp_done;

  assign evt_ready = !evt_pend_q;
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= SRC_EVENT;
      last_grant_q <= SRC_EVENT;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  // last_grant only moves when both sources contend, so a lone source never steals the next turn.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (samp_pend_q || evt_pend_q) begin
          state_d = HDR1;
          if (samp_pend_q && evt_pend_q) begin
            src_d        = (last_grant_q == SRC_EVENT) ? SRC_SAMPLE : SRC_EVENT;
            last_grant_d = src_d;
          end else begin
            src_d = samp_pend_q ? SRC_SAMPLE : SRC_EVENT;
          end
        end
      end
      HDR1: if (tx_ack) state_d = HDR2;
      HDR2: if (tx_ack) state_d = TYPE;
      TYPE: if (tx_ack) state_d = PAY;
      PAY: begin
        if (tx_ack && pay_last) begin
`ifdef DEBUG_FRAME_CSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
`endif
        end
      end
      CSUM: if (tx_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    unique case (state_q)
      IDLE: ;
      HDR1: begin tx_valid = 1'b1; tx_byte = MAGIC1; end
      HDR2: begin tx_valid = 1'b1; tx_byte = MAGIC2; end
      TYPE: begin
        tx_valid = 1'b1;
        tx_byte  = (src_q == SRC_SAMPLE) ? TYPE_SAMPLE : TYPE_EVENT;
      end
      PAY:  begin tx_valid = 1'b1; tx_byte = pay_byte; end
      CSUM: begin
`ifdef DEBUG_FRAME_CSUM_EN
        tx_valid = 1'b1;
        tx_byte  = csum_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_pend_q <= 1'b0;
      evt_pend_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
      pay_idx_q   <= '0;
    end else begin
      if (samp_take)     samp_pend_q <= 1'b1;
      else if (samp_done) samp_pend_q <= 1'b0;

      if (evt_valid && !evt_pend_q) evt_pend_q <= 1'b1;
      else if (evt_done)            evt_pend_q <= 1'b0;

      // The drop_cnt byte is the last event byte, so its ack doubles as the clear.
      if (evt_done)                           drop_cnt_q <= {7'b0, samp_drop};
      else if (samp_drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;

      if (state_q != PAY) pay_idx_q <= '0;
      else if (tx_ack)    pay_idx_q <= pay_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (samp_take) snap_q <= samples;
    if (evt_valid && !evt_pend_q) evt_code_q <= evt_code;
  end

`ifdef DEBUG_FRAME_CSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                             csum_q <= 8'h00;
    else if (state_q == TYPE && tx_ack)  csum_q <= tx_byte;
    else if (state_q == PAY && tx_ack)   csum_q <= csum_q ^ tx_byte;
  end
`endif

  uart_tx u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .data_i  (tx_byte),
    .valid_i (tx_valid),
    .ack_o   (tx_ack),
    .div_i   (16'(DIV - 2)),
    .tx_o    (tx_o)
  );

endmodule

// File: tb/tb_debug_frame_sched.sv
// Directed bench for debug_frame_sched: decodes the UART line and compares whole frames.
`timescale 1ns/1ps
module tb_debug_frame_sched;

  localparam int W   = 16;
  localparam int NCH = 8;
  localparam int DIV = 12;
  localparam int NB  = NCH * W / 8;
`ifdef DEBUG_FRAME_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int FL_S = 3 + NB + CS;
  localparam int FL_E = 5 + CS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_strobe = 1'b0;
  logic [NCH*W-1:0] samples = '0;
  logic             evt_valid = 1'b0;
  logic [7:0]       evt_code = 8'h00;
  logic             evt_ready;
  logic             tx_o;
  logic             busy;
  logic [7:0]       drop_cnt;

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         n_starts = 0;
  int         start_cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  debug_frame_sched #(.W(W), .NCH(NCH), .DIV(DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_strobe (sample_strobe),
    .samples       (samples),
    .evt_valid     (evt_valid),
    .evt_code      (evt_code),
    .evt_ready     (evt_ready),
    .tx_o          (tx_o),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial receiver: samples mid-bit on the falling clock edge.
  initial begin : rx
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        n_starts++;
        start_cyc = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (DIV) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, summary: %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_strobe(input logic [NCH*W-1:0] v);
    samples = v;
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
  endtask

  task automatic post_event(input logic [7:0] code);
    evt_code = code;
    evt_valid = 1'b1;
    tick(1);
    evt_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int k = 0;
    while (rxq.size() < n && k < 20000) begin tick(1); k++; end
    ok = (rxq.size() >= n);
  endtask

  task automatic wait_starts(input int n, output bit ok);
    int k = 0;
    while (n_starts < n && k < 20000) begin tick(1); k++; end
    ok = (n_starts >= n);
  endtask

  task automatic push_sample_frame(input logic [NCH*W-1:0] v);
    logic [7:0] x = 8'h01;
    expq.push_back(8'hBE); expq.push_back(8'hEF); expq.push_back(8'h01);
    for (int ch = 0; ch < NCH; ch++) begin
      expq.push_back(v[ch*W+8 +: 8]); x ^= v[ch*W+8 +: 8];
      expq.push_back(v[ch*W +: 8]);   x ^= v[ch*W +: 8];
    end
    if (CS != 0) expq.push_back(x);
  endtask

  task automatic push_event_frame(input logic [7:0] code, input logic [7:0] drops);
    expq.push_back(8'hBE); expq.push_back(8'hEF); expq.push_back(8'h02);
    expq.push_back(code); expq.push_back(drops);
    if (CS != 0) expq.push_back(8'h02 ^ code ^ drops);
  endtask

  task automatic test_reset();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (evt_ready !== 1'b1) $display("FAIL reset_evt_ready: got %b expected 1", evt_ready); else n_pass++;
    n_total++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop_cnt: got %02h expected 00", drop_cnt); else n_pass++;
    n_total++; if (tx_o !== 1'b1) $display("FAIL reset_tx_idle: got %b expected 1", tx_o); else n_pass++;
    tick(20);
    n_total++; if (busy !== 1'b0 || rxq.size() != 0) $display("FAIL reset_quiet: busy %b bytes %0d expected 0/0", busy, rxq.size()); else n_pass++;
  endtask

  task automatic test_sample_frame();
    logic [NCH*W-1:0] v = '0;
    logic [7:0] got;
    bit ok;
    v[0*W +: W] = 16'h1234;
    v[7*W +: W] = 16'h8001;
    expq.delete();
    expq.push_back(8'hBE); expq.push_back(8'hEF); expq.push_back(8'h01);
    expq.push_back(8'h12); expq.push_back(8'h34);
    for (int i = 0; i < 12; i++) expq.push_back(8'h00);
    expq.push_back(8'h80); expq.push_back(8'h01);
    if (CS != 0) expq.push_back(8'hA6);
    pulse_strobe(v);
    tick(1);
    n_total++; if (busy !== 1'b1) $display("FAIL sample_busy_start: got %b expected 1", busy); else n_pass++;
    wait_bytes(FL_S, ok);
    n_total++; if (!ok) $display("FAIL sample_timeout: got %0d bytes expected %0d", rxq.size(), FL_S); else n_pass++;
    for (int i = 0; i < expq.size(); i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      n_total++; if (got !== expq[i]) $display("FAIL sample_byte[%0d]: got %02h expected %02h", i, got, expq[i]); else n_pass++;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL sample_busy_end: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_event_frame();
    logic [7:0] got;
    bit ok;
    int base = n_starts;
    expq.delete();
    expq.push_back(8'hBE); expq.push_back(8'hEF); expq.push_back(8'h02);
    expq.push_back(8'h5A); expq.push_back(8'h00);
    if (CS != 0) expq.push_back(8'h58);
    post_event(8'h5A);
    n_total++; if (evt_ready !== 1'b0) $display("FAIL event_ready_taken: got %b expected 0", evt_ready); else n_pass++;
    wait_starts(base + 4, ok);
    n_total++; if (!ok || evt_ready !== 1'b0) $display("FAIL event_ready_mid: ok %0d ready %b expected 1/0", ok, evt_ready); else n_pass++;
    wait_starts(base + 5, ok);
    n_total++; if (!ok || evt_ready !== 1'b1) $display("FAIL event_ready_after: ok %0d ready %b expected 1/1", ok, evt_ready); else n_pass++;
    wait_bytes(FL_E, ok);
    n_total++; if (!ok) $display("FAIL event_timeout: got %0d bytes expected %0d", rxq.size(), FL_E); else n_pass++;
    for (int i = 0; i < expq.size(); i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      n_total++; if (got !== expq[i]) $display("FAIL event_byte[%0d]: got %02h expected %02h", i, got, expq[i]); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [NCH*W-1:0] v1 = {8{16'hA55A}};
    logic [NCH*W-1:0] v2 = {8{16'h0FF0}};
    logic [7:0] got;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      expq.delete();
      if (pass == 0) begin push_sample_frame(v1); push_event_frame(8'hA1, 8'h00); end
      else           begin push_event_frame(8'hB2, 8'h00); push_sample_frame(v2); end
      samples = (pass == 0) ? v1 : v2;
      evt_code = (pass == 0) ? 8'hA1 : 8'hB2;
      sample_strobe = 1'b1;
      evt_valid = 1'b1;
      tick(1);
      sample_strobe = 1'b0;
      evt_valid = 1'b0;
      wait_bytes(FL_S + FL_E, ok);
      n_total++; if (!ok) $display("FAIL rr%0d_timeout: got %0d bytes expected %0d", pass, rxq.size(), FL_S + FL_E); else n_pass++;
      for (int i = 0; i < expq.size(); i++) begin
        got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
        n_total++; if (got !== expq[i]) $display("FAIL rr%0d_byte[%0d]: got %02h expected %02h", pass, i, got, expq[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_drop_saturate();
    logic [NCH*W-1:0] v3 = {16'h7001, 16'h6002, 16'h5003, 16'h4004, 16'h3005, 16'h2006, 16'h1007, 16'h0008};
    logic [7:0] got;
    bit ok;
    expq.delete();
    push_sample_frame(v3);
    push_event_frame(8'hC3, 8'hFF);
    pulse_strobe(v3);
    tick(2);
    for (int i = 0; i < 300; i++) begin
      samples = {NCH{i[15:0]}};
      sample_strobe = 1'b1;
      tick(1);
    end
    sample_strobe = 1'b0;
    n_total++; if (drop_cnt !== 8'hFF) $display("FAIL drop_saturate: got %02h expected ff", drop_cnt); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL drop_busy: got %b expected 1", busy); else n_pass++;
    post_event(8'hC3);
    wait_bytes(FL_S + FL_E, ok);
    n_total++; if (!ok) $display("FAIL drop_timeout: got %0d bytes expected %0d", rxq.size(), FL_S + FL_E); else n_pass++;
    for (int i = 0; i < expq.size(); i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      n_total++; if (got !== expq[i]) $display("FAIL drop_byte[%0d]: got %02h expected %02h", i, got, expq[i]); else n_pass++;
    end
    n_total++; if (drop_cnt !== 8'h00) $display("FAIL drop_cleared: got %02h expected 00", drop_cnt); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [NCH*W-1:0] v4 = {8{16'hDEAD}};
    logic [NCH*W-1:0] v5 = {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
    logic [7:0] got;
    bit ok;
    int base = n_starts;
    pulse_strobe(v4);
    pulse_strobe(v5);
    pulse_strobe(v5);
    pulse_strobe(v5);
    post_event(8'h77);
    n_total++; if (drop_cnt !== 8'd3 || evt_ready !== 1'b0) $display("FAIL rstmid_pre: drop %02h ready %b expected 03/0", drop_cnt, evt_ready); else n_pass++;
    wait_starts(base + 6, ok);
    n_total++; if (!ok) $display("FAIL rstmid_start_timeout: got %0d starts expected %0d", n_starts - base, 6); else n_pass++;
    tick(DIV * 3);
    rst = 1'b1;
    tick(1);
    n_total++; if (tx_o !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (drop_cnt !== 8'h00) $display("FAIL rstmid_drop: got %02h expected 00", drop_cnt); else n_pass++;
    n_total++; if (evt_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", evt_ready); else n_pass++;
    tick(1);
    rst = 1'b0;
    tick(12 * DIV);
    n_total++; if (busy !== 1'b0 || tx_o !== 1'b1) $display("FAIL rstmid_quiet: busy %b tx %b expected 0/1", busy, tx_o); else n_pass++;
    rxq.delete();
    expq.delete();
    push_sample_frame(v5);
    pulse_strobe(v5);
    wait_bytes(FL_S, ok);
    n_total++; if (!ok) $display("FAIL rstmid_timeout: got %0d bytes expected %0d", rxq.size(), FL_S); else n_pass++;
    for (int i = 0; i < expq.size(); i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      n_total++; if (got !== expq[i]) $display("FAIL rstmid_byte[%0d]: got %02h expected %02h", i, got, expq[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [NCH*W-1:0] v6 = {8{16'h1357}};
    logic [NCH*W-1:0] v7 = {16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 16'h0011, 16'h2233, 16'h4455, 16'h6677};
    logic [7:0] got;
    bit ok;
    int base = n_starts;
    int tgt;
    expq.delete();
    push_sample_frame(v6);
    push_sample_frame(v7);
    pulse_strobe(v6);
    // Start of the second-to-last payload byte; the last one is acked 10*DIV+1 cycles later.
    wait_starts(base + 18, ok);
    n_total++; if (!ok) $display("FAIL b2b_start_timeout: got %0d starts expected %0d", n_starts - base, 18); else n_pass++;
    tgt = start_cyc + 10 * DIV;
    while (cyc < tgt) tick(1);
    samples = v7;
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
    n_total++; if (drop_cnt !== 8'h00) $display("FAIL b2b_no_drop: got %02h expected 00", drop_cnt); else n_pass++;
    wait_bytes(2 * FL_S, ok);
    n_total++; if (!ok) $display("FAIL b2b_timeout: got %0d bytes expected %0d", rxq.size(), 2 * FL_S); else n_pass++;
    for (int i = 0; i < expq.size(); i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      n_total++; if (got !== expq[i]) $display("FAIL b2b_byte[%0d]: got %02h expected %02h", i, got, expq[i]); else n_pass++;
    end
    n_total++; if (busy !== 1'b0 || drop_cnt !== 8'h00) $display("FAIL b2b_end: busy %b drop %02h expected 0/00", busy, drop_cnt); else n_pass++;
  endtask

  initial begin : main
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    test_reset();
    test_sample_frame();
    test_event_frame();
    test_round_robin();
    test_drop_saturate();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
